// File: rtl/reg4_ser_pkg.sv
// Shared encodings for the serial nibble link (transmitter and matching receiver).
package reg4_ser_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } ser_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/reg4_serial_tx_if.sv
// Parallel load side and serial/status outputs of the nibble transmitter.
interface reg4_serial_tx_if #(
  parameter int WIDTH = 4
) ();
  logic [WIDTH-1:0] d;
  logic             en;
  logic             txd;
  logic             busy;
  logic             full;
  logic             done;
  logic             ovr;

  modport master (output d, en, input txd, busy, full, done, ovr);
  modport slave  (input d, en, output txd, busy, full, done, ovr);
endinterface

// File: rtl/ser_bit_timer.sv
// Bit-period divider: counts 0..DIV-1 and flags the last cycle of each serial bit.
module ser_bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic clr_b,
  input  logic restart,
  output logic bit_end,
  output logic bit_end_next
);
  localparam int DW = $clog2(DIV) + 1;
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] PRE  = DW'((DIV >= 2) ? DIV - 2 : 0);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!clr_b) begin
      cnt <= '0;
    end else if (restart || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DW'(1);
    end
  end

  assign bit_end = (cnt == LAST);
  // Valid while the timer free-runs; says the following cycle will be a bit's last.
  assign bit_end_next = (DIV == 1) ? 1'b1 : (cnt == PRE);
endmodule

// File: rtl/reg4_serial_tx.sv
// Serial transmitter: frames a loaded word as start, WIDTH data bits LSB-first, stop.
//
// state   | meaning
// S_IDLE  | line high, waiting for a load strobe
// S_START | driving the start bit for DIV cycles
// S_DATA  | shifting WIDTH data bits out, LSB first
// S_STOP  | driving the stop bit; DONE on its last cycle
module reg4_serial_tx
  import reg4_ser_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             clr_b,
  reg4_serial_tx_if.slave  bus
);
  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_nx;
  logic [WIDTH-1:0] hold;
  logic [BW-1:0]    bit_cnt;
  logic             txd, busy, full, done, ovr;
  logic             bit_end, bit_end_next;
  logic             stop_end, next_stop;

  ser_bit_timer #(.DIV(DIV)) u_timer (
    .clk          (clk),
    .clr_b        (clr_b),
    .restart      (state == S_IDLE),
    .bit_end      (bit_end),
    .bit_end_next (bit_end_next)
  );

  assign shift_nx  = shift >> 1;
  assign stop_end  = (state == S_STOP) && bit_end;
  assign next_stop = ((state == S_STOP) && !bit_end) ||
                     ((state == S_DATA) && bit_end && (bit_cnt == LAST_BIT));

  always_ff @(posedge clk) begin
    if (!clr_b) begin
      state   <= S_IDLE;
      shift   <= '0;
      hold    <= '0;
      bit_cnt <= '0;
      txd     <= LINE_IDLE;
      busy    <= 1'b0;
      full    <= 1'b0;
      done    <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      done <= next_stop && bit_end_next;
      ovr  <= 1'b0;

      // The last stop cycle hands the held word over, so a new load there refills the hold.
      if ((state != S_IDLE) && bus.en) begin
        if (stop_end) begin
          if (full) hold <= bus.d;
        end else if (!full) begin
          hold <= bus.d;
          full <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (bus.en) begin
            shift <= bus.d;
            txd   <= START_BIT;
            busy  <= 1'b1;
            state <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            txd     <= shift[0];
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              txd     <= LINE_IDLE;
              state   <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              shift   <= shift_nx;
              txd     <= shift_nx[0];
            end
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (full) begin
              shift <= hold;
              if (!bus.en) full <= 1'b0;
              txd   <= START_BIT;
              state <= S_START;
            end else if (bus.en) begin
              shift <= bus.d;
              txd   <= START_BIT;
              state <= S_START;
            end else begin
              busy  <= 1'b0;
              txd   <= LINE_IDLE;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.txd  = txd;
  assign bus.busy = busy;
  assign bus.full = full;
  assign bus.done = done;
  assign bus.ovr  = ovr;
endmodule

// File: tb/tb_reg4_serial_tx.sv
// Bench for reg4_serial_tx: frame-level reference model feeding a scoreboard of sent words.
module tb_reg4_serial_tx;
  localparam int W   = 4;
  localparam int DIV = 4;
  localparam int F   = (W + 2) * DIV;

  logic clk = 1'b0;
  logic clr_b;
  always #5 clk = ~clk;

  reg4_serial_tx_if #(.WIDTH(W)) bus ();

  reg4_serial_tx #(.WIDTH(W), .DIV(DIV)) dut (
    .clk   (clk),
    .clr_b (clr_b),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // Reference model: words accepted for transmission, in send order.
  logic [W-1:0] exp_q[$];
  bit m_busy = 0;
  bit m_full = 0;
  bit m_ovr  = 0;
  int m_rem  = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(bit rst_b, bit en, logic [W-1:0] d);
    clr_b  = rst_b;
    bus.en = en;
    bus.d  = d;
    @(posedge clk);
    m_ovr = 0;
    if (!rst_b) begin
      m_busy = 0;
      m_full = 0;
      m_rem  = 0;
      exp_q.delete();
    end else if (m_busy) begin
      if (m_rem == 1) begin
        m_rem = F;
        if (m_full) begin
          if (en) exp_q.push_back(d);
          else m_full = 0;
        end else if (en) begin
          exp_q.push_back(d);
        end else begin
          m_busy = 0;
        end
      end else begin
        m_rem--;
        if (en) begin
          if (!m_full) begin
            m_full = 1;
            exp_q.push_back(d);
          end else begin
            m_ovr = 1;
          end
        end
      end
    end else if (en) begin
      m_busy = 1;
      m_rem  = F;
      exp_q.push_back(d);
    end
    @(negedge clk);
    chk("busy", int'(bus.busy), int'(m_busy));
    chk("full", int'(bus.full), int'(m_full));
    chk("done", int'(bus.done), int'(m_busy && m_rem == 1));
    chk("ovr",  int'(bus.ovr),  int'(m_ovr));
    if (!m_busy) chk("txd_idle", int'(bus.txd), 1);
  endtask

  // Monitor: rebuilds each frame from TXD and scores it on DONE.
  initial begin
    int cyc;
    logic bits [0:F-1];
    cyc = 0;
    wait (started);
    forever begin
      @(negedge clk);
      if (!bus.busy) begin
        cyc = 0;
      end else begin
        if (cyc < F) bits[cyc] = bus.txd;
        if (bus.done) begin
          logic [W-1:0] word;
          bit ok;
          ok = 1;
          for (int i = 0; i < DIV; i++) begin
            if (bits[i] !== 1'b0) ok = 0;
            if (bits[F-DIV+i] !== 1'b1) ok = 0;
          end
          for (int b = 0; b < W; b++) begin
            word[b] = bits[DIV*(b+1)];
            for (int k = 0; k < DIV; k++)
              if (bits[DIV*(b+1)+k] !== word[b]) ok = 0;
          end
          chk("frame_len", cyc, F - 1);
          chk("framing", int'(ok), 1);
          if (exp_q.size() == 0) chk("frame_expected", 0, 1);
          else chk("frame_word", int'(word), int'(exp_q.pop_front()));
          cyc = 0;
        end else begin
          cyc++;
          if (cyc >= F) begin
            chk("frame_overlong", cyc, F - 1);
            cyc = 0;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.en = 1'b0;
    bus.d  = '0;
    clr_b  = 1'b0;

    // Reset, including a load strobe that reset must dominate.
    step(0, 0, 4'h0);
    started = 1;
    step(0, 1, 4'hF);
    repeat (3) step(1, 0, 4'h0);
    step(0, 0, 4'h0);
    chk("reset_txd", int'(bus.txd), 1);
    repeat (2) step(1, 0, 4'h0);

    // Single frame.
    step(1, 1, 4'b1110);
    chk("start_txd", int'(bus.txd), 0);
    repeat (30) step(1, 0, 4'h0);

    // Back-to-back through the holding register.
    step(1, 1, 4'b1011);
    repeat (4) step(1, 0, 4'h0);
    step(1, 1, 4'b0011);
    repeat (60) step(1, 0, 4'h0);

    // Overrun on the third load.
    step(1, 1, 4'b1011);
    repeat (2) step(1, 0, 4'h0);
    step(1, 1, 4'b0011);
    repeat (3) step(1, 0, 4'h0);
    step(1, 1, 4'b0100);
    chk("ovr_third_load", int'(bus.ovr), 1);
    repeat (60) step(1, 0, 4'h0);

    // Reset mid-frame, then a clean frame.
    step(1, 1, 4'b1010);
    repeat (9) step(1, 0, 4'h0);
    step(0, 0, 4'h0);
    chk("abort_txd", int'(bus.txd), 1);
    step(1, 1, 4'b0100);
    repeat (30) step(1, 0, 4'h0);

    // Load on the DONE cycle with an empty hold.
    step(1, 1, 4'b0110);
    for (int i = 0; i < F && m_rem != 1; i++) step(1, 0, 4'h0);
    chk("done_seen", int'(bus.done), 1);
    step(1, 1, 4'b1001);
    chk("chain_txd", int'(bus.txd), 0);
    chk("chain_full", int'(bus.full), 0);
    repeat (60) step(1, 0, 4'h0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 2500; n++) begin
      bit r, e;
      r = ($urandom_range(0, 299) != 0);
      e = ($urandom_range(0, 9) < 2);
      step(r, e, W'($urandom));
    end

    for (int i = 0; i < 3 * F && m_busy; i++) step(1, 0, 4'h0);
    repeat (2) step(1, 0, 4'h0);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
